// File: rtl/rx_rss_sched_pkg.sv
// rtl/rx_rss_sched_pkg.sv - shared widths, CSR map and FSM states for the RSS queue scheduler
package rx_rss_sched_pkg;
   localparam int HASH_WIDTH = 32;
   localparam int KEY_WIDTH  = 320;
   localparam int KEY_WORDS  = KEY_WIDTH / 32;
   localparam int KEY_IDX_W  = $clog2(KEY_WIDTH);

   localparam logic [7:0] ADDR_CTRL       = 8'h00;
   localparam logic [7:0] ADDR_KEY_COMMIT = 8'h01;
   localparam logic [7:0] ADDR_KEY_BASE   = 8'h10;
   localparam logic [7:0] ADDR_TBL_BASE   = 8'h80;

   localparam int CTRL_EN_BIT = 0;
   localparam int CTRL_DQ_LSB = 8;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } sched_state_e;
endpackage

// File: rtl/rss_hash_fifo.sv
// rtl/rss_hash_fifo.sv - synchronous hash-result FIFO with full/empty flags
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module rss_hash_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end
endmodule

// File: rtl/rx_rss_sched.sv
// rtl/rx_rss_sched.sv - RSS queue scheduler: hash FIFO, indirection lookup, key/CSR ownership
// The table has one port; init fill, lookup, then CSR access is the order of priority.
module rx_rss_sched
   import rx_rss_sched_pkg::*;
#(
   parameter int TBL_DEPTH  = 128,
   parameter int QNUM_WIDTH = 8,
   parameter int NUM_QUEUES = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [HASH_WIDTH-1:0] i_crx_hash,
   input  logic                  i_crx_hash_valid,
   input  logic                  i_frame_idle,
   output logic [KEY_WIDTH-1:0]  o_hash_key,
   output logic                  o_q_valid,
   input  logic                  i_q_ready,
   output logic [QNUM_WIDTH-1:0] o_q_num,
   output logic [HASH_WIDTH-1:0] o_q_hash,
   input  logic                  i_cfg_wr_en,
   input  logic                  i_cfg_rd_en,
   input  logic [7:0]            i_cfg_addr,
   input  logic [31:0]           i_cfg_wdata,
   output logic                  o_cfg_ready,
   output logic [31:0]           o_cfg_rdata,
   output logic                  o_cfg_rd_valid,
   output logic [15:0]           o_drop_cnt
);
   localparam int IDX_W = $clog2(TBL_DEPTH);

   sched_state_e          r_state;
   sched_state_e          w_state_nxt;
   logic [IDX_W-1:0]      r_init_idx;
   logic [QNUM_WIDTH-1:0] r_init_q;

   logic [QNUM_WIDTH-1:0] r_tbl [TBL_DEPTH];
   logic [IDX_W-1:0]      w_tbl_addr;
   logic                  w_tbl_we;
   logic [QNUM_WIDTH-1:0] w_tbl_wdata;
   logic [QNUM_WIDTH-1:0] w_tbl_rd;

   logic                  r_ctrl_en;
   logic [QNUM_WIDTH-1:0] r_ctrl_dq;
   logic [KEY_WIDTH-1:0]  r_key_shadow;
   logic [KEY_WIDTH-1:0]  w_shadow_nxt;
   logic [KEY_WIDTH-1:0]  r_hash_key;
   logic                  r_commit_pend;

   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [HASH_WIDTH-1:0] w_fifo_data;
   logic                  w_pop;
   logic                  w_drop;

   logic                  r_q_valid;
   logic [QNUM_WIDTH-1:0] r_q_num;
   logic [HASH_WIDTH-1:0] r_q_hash;
   logic [31:0]           r_cfg_rdata;
   logic                  r_cfg_rd_valid;
   logic [15:0]           r_drop_cnt;

   logic                  w_cfg_ready;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [7:0]            w_tbl_off;
   logic [7:0]            w_key_off;
   logic                  w_is_tbl;
   logic                  w_is_key;
   logic [KEY_IDX_W-1:0]  w_key_lsb;
   logic [31:0]           w_rd_word;

   rss_hash_fifo #(
      .WIDTH (HASH_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_crx_hash_valid),
      .i_data  (i_crx_hash),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && r_init_idx == IDX_W'(TBL_DEPTH - 1)) begin
         w_state_nxt = ST_RUN;
      end
   end

   // r_init_q tracks idx % NUM_QUEUES without a divider.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_init_idx <= '0;
         r_init_q   <= '0;
      end else if (r_state == ST_INIT) begin
         r_init_idx <= r_init_idx + IDX_W'(1);
         r_init_q   <= (r_init_q == QNUM_WIDTH'(NUM_QUEUES - 1)) ? '0 : r_init_q + QNUM_WIDTH'(1);
      end
   end

   assign w_pop       = (r_state == ST_RUN) & ~w_fifo_empty & (~r_q_valid | i_q_ready);
   assign w_cfg_ready = (r_state == ST_RUN) & ~w_pop;
   assign w_wr_acc    = w_cfg_ready & i_cfg_wr_en;
   assign w_rd_acc    = w_cfg_ready & i_cfg_rd_en & ~i_cfg_wr_en;
   assign w_drop      = i_crx_hash_valid & w_fifo_full & ~w_pop;

   assign w_tbl_off = i_cfg_addr - ADDR_TBL_BASE;
   assign w_key_off = i_cfg_addr - ADDR_KEY_BASE;
   assign w_is_tbl  = (i_cfg_addr >= ADDR_TBL_BASE) && (int'(w_tbl_off) < TBL_DEPTH);
   assign w_is_key  = (i_cfg_addr >= ADDR_KEY_BASE) && (int'(w_key_off) < KEY_WORDS);
   // Shadow word 0 is the most significant 32 bits of the key.
   assign w_key_lsb = KEY_IDX_W'(KEY_WIDTH - 32 * (int'(w_key_off[3:0]) + 1));

   always_comb begin
      w_tbl_we    = 1'b0;
      w_tbl_addr  = w_fifo_data[IDX_W-1:0];
      w_tbl_wdata = r_init_q;
      if (r_state == ST_INIT) begin
         w_tbl_we   = 1'b1;
         w_tbl_addr = r_init_idx;
      end else if (!w_pop && w_is_tbl) begin
         w_tbl_addr  = w_tbl_off[IDX_W-1:0];
         w_tbl_we    = w_wr_acc;
         w_tbl_wdata = i_cfg_wdata[QNUM_WIDTH-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_tbl_we) begin
         r_tbl[w_tbl_addr] <= w_tbl_wdata;
      end
   end

   assign w_tbl_rd = r_tbl[w_tbl_addr];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q_valid <= 1'b0;
         r_q_num   <= '0;
         r_q_hash  <= '0;
      end else if (w_pop) begin
         r_q_valid <= 1'b1;
         r_q_num   <= r_ctrl_en ? w_tbl_rd : r_ctrl_dq;
         r_q_hash  <= w_fifo_data;
      end else if (i_q_ready) begin
         r_q_valid <= 1'b0;
      end
   end

   always_comb begin
      w_shadow_nxt = r_key_shadow;
      if (w_wr_acc && w_is_key) begin
         w_shadow_nxt[w_key_lsb +: 32] = i_cfg_wdata;
      end
   end

   always_comb begin
      w_rd_word = '0;
      if (i_cfg_addr == ADDR_CTRL) begin
         w_rd_word[CTRL_EN_BIT]               = r_ctrl_en;
         w_rd_word[CTRL_DQ_LSB +: QNUM_WIDTH] = r_ctrl_dq;
      end else if (w_is_key) begin
         w_rd_word = r_key_shadow[w_key_lsb +: 32];
      end else if (w_is_tbl) begin
         w_rd_word[QNUM_WIDTH-1:0] = w_tbl_rd;
      end
   end

   // The copy uses the post-write shadow so a same-cycle shadow write is not lost.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ctrl_en      <= 1'b0;
         r_ctrl_dq      <= '0;
         r_key_shadow   <= '0;
         r_hash_key     <= '0;
         r_commit_pend  <= 1'b0;
         r_cfg_rdata    <= '0;
         r_cfg_rd_valid <= 1'b0;
      end else begin
         r_cfg_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_cfg_rdata <= w_rd_word;
         end
         if (w_wr_acc && i_cfg_addr == ADDR_CTRL) begin
            r_ctrl_en <= i_cfg_wdata[CTRL_EN_BIT];
            r_ctrl_dq <= i_cfg_wdata[CTRL_DQ_LSB +: QNUM_WIDTH];
         end
         r_key_shadow <= w_shadow_nxt;
         if (w_wr_acc && i_cfg_addr == ADDR_KEY_COMMIT) begin
            r_commit_pend <= 1'b1;
         end
         if (r_commit_pend && i_frame_idle) begin
            r_hash_key    <= w_shadow_nxt;
            r_commit_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_drop_cnt <= '0;
      end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign o_hash_key     = r_hash_key;
   assign o_q_valid      = r_q_valid;
   assign o_q_num        = r_q_num;
   assign o_q_hash       = r_q_hash;
   assign o_cfg_ready    = w_cfg_ready;
   assign o_cfg_rdata    = r_cfg_rdata;
   assign o_cfg_rd_valid = r_cfg_rd_valid;
   assign o_drop_cnt     = r_drop_cnt;
endmodule
